bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_pkg.sv | 15 +
 rtl/bcd_digit_cell.sv | 54 +++++
 rtl/bcd_scan_counter.sv | 122 ++++++++++++
 tb/tb_bcd_scan_counter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD scan counter.
//   bcd_t          : one BCD decade (4 bits, legal codes 0..9)
//   BCD_MAX/MIN    : decade limits
//   *_DEF          : default parameter values for bcd_scan_counter
package bcd_scan_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   localparam int unsigned NUM_DIGITS_DEF = 4;
   localparam int unsigned SCAN_DIV_DEF   = 16;

endpackage : bcd_scan_pkg

// File: rtl/bcd_digit_cell.sv
// One BCD decade with synchronous clear and up/down step.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over step)
//   step       : count-step request for the whole counter
//   up         : 1 = increment, 0 = decrement
//   cin        : carry-in (up) / borrow-in (down) from the lower decade
//   value      : registered decade value, always 0..9
//   nxt_c      : value this decade will hold after the next edge
//   cout_c     : carry-out (up) / borrow-out (down) to the higher decade
module bcd_digit_cell
   import bcd_scan_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic step,
   input  logic up,
   input  logic cin,
   output bcd_t value,
   output bcd_t nxt_c,
   output logic cout_c
);

   logic at_lim_c;
   logic move_c;

   // Next-value and carry/borrow generation
   always_comb begin
      at_lim_c = up ? (value == BCD_MAX) : (value == BCD_MIN);
      move_c   = step & cin;
      cout_c   = move_c & at_lim_c;
      nxt_c    = value;
      if (clr) begin
         nxt_c = BCD_MIN;
      end else if (move_c) begin
         if (up) begin
            nxt_c = at_lim_c ? BCD_MIN : bcd_t'(value + 4'd1);
         end else begin
            nxt_c = at_lim_c ? BCD_MAX : bcd_t'(value - 4'd1);
         end
      end
   end

   // Decade register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= BCD_MIN;
      end else begin
         value <= nxt_c;
      end
   end

endmodule : bcd_digit_cell

// File: rtl/bcd_scan_counter.sv
// Multi-decade BCD up/down counter with a multiplexed digit scan for a
// segment display.
// Optional build macro: BCD_SCAN_BLANK_EN -- leading-zero blanking; the
// digit enable is dropped while scanning a decade (index > 0) that, along
// with every higher decade, is zero. Decade 0 is always shown.
// Parameters:
//   NUM_DIGITS : number of decades (1..8)
//   SCAN_DIV   : clocks each decade stays selected (>= 2)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count-step request
//   up         : 1 = count up, 0 = count down
//   clr        : synchronous clear of the count (priority over en)
//   count_bcd  : registered count, nibble 0 = least-significant decade
//   digit      : registered BCD nibble of the scanned decade
//   digit_sel  : registered active-high decade enable (one-hot, or zero when blanked)
//   wrap       : registered one-cycle pulse on roll-over / roll-under
module bcd_scan_counter
   import bcd_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic [3:0]              digit,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    wrap
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);

   logic [NUM_DIGITS:0]       carry_c;
   logic [4*NUM_DIGITS-1:0]   count_nxt_c;
   logic [DIV_W-1:0]          div_q;
   logic [DIV_W-1:0]          div_nxt_c;
   logic [IDX_W-1:0]          idx_q;
   logic [IDX_W-1:0]          idx_nxt_c;
   logic [NUM_DIGITS-1:0]     sel_nxt_c;
   bcd_t                      digit_nxt_c;

   // Decade 0 always sees a carry/borrow-in; the top carry marks a wrap
   assign carry_c[0] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .step   (en),
         .up     (up),
         .cin    (carry_c[i]),
         .value  (count_bcd[4*i +: 4]),
         .nxt_c  (count_nxt_c[4*i +: 4]),
         .cout_c (carry_c[i+1])
      );
   end

   // Scan divider and decade index
   always_comb begin
      div_nxt_c = div_q + DIV_W'(1);
      idx_nxt_c = idx_q;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
         div_nxt_c = '0;
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt_c = '0;
         end else begin
            idx_nxt_c = idx_q + IDX_W'(1);
         end
      end
   end

   // Digit mux and enable from the post-edge count and index
   always_comb begin
      digit_nxt_c = BCD_MIN;
      sel_nxt_c   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx_nxt_c) begin
            digit_nxt_c  = count_nxt_c[4*i +: 4];
            sel_nxt_c[i] = 1'b1;
         end
      end
`ifdef BCD_SCAN_BLANK_EN
      // Walk down from the top decade; hi_zero covers decades i..top
      begin : b_blank
         logic hi_zero;
         hi_zero = 1'b1;
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (count_nxt_c[4*i +: 4] != BCD_MIN) begin
               hi_zero = 1'b0;
            end
            if ((IDX_W'(i) == idx_nxt_c) && hi_zero) begin
               sel_nxt_c = '0;
            end
         end
      end
`endif
   end

   // Scan state and display/wrap output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= '0;
         idx_q     <= '0;
         digit     <= BCD_MIN;
         digit_sel <= NUM_DIGITS'(1);
         wrap      <= 1'b0;
      end else begin
         div_q     <= div_nxt_c;
         idx_q     <= idx_nxt_c;
         digit     <= digit_nxt_c;
         digit_sel <= sel_nxt_c;
         wrap      <= ~clr & carry_c[NUM_DIGITS];
      end
   end

endmodule : bcd_scan_counter

// File: tb/tb_bcd_scan_counter.sv
// Directed self-checking bench for bcd_scan_counter (4 decades, SCAN_DIV=4).
module tb_bcd_scan_counter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up;
   logic        clr;
   logic [15:0] count_bcd;
   logic [3:0]  digit;
   logic [3:0]  digit_sel;
   logic        wrap;

   int checks;
   int errors;
   int exp_cnt;

   bcd_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .up        (up),
      .clr       (clr),
      .count_bcd (count_bcd),
      .digit     (digit),
      .digit_sel (digit_sel),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p10(input int i);
      int r;
      r = 1;
      for (int j = 0; j < i; j++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
      return r;
   endfunction

   function automatic logic [3:0] model_digit(input int idx, input int v);
      return 4'((v / p10(idx)) % 10);
   endfunction

   function automatic logic [3:0] model_sel(input int idx, input int v);
      logic [3:0] s;
      s = 4'b0001 << idx;
`ifdef BCD_SCAN_BLANK_EN
      if (idx > 0 && (v / p10(idx)) == 0) s = 4'b0000;
`endif
      return s;
   endfunction

   // Stimulus helpers: start and end right after a falling edge
   task automatic do_steps(input int n, input logic dir);
      en = 1'b1;
      up = dir;
      repeat (n) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < n; i++) exp_cnt = dir ? (exp_cnt + 1) % 10000 : (exp_cnt + 9999) % 10000;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0;
   endtask

   // Waits until decade 0 has just become selected (index 0, first cycle)
   task automatic sync_scan(output bit ok);
      logic [3:0] prev;
      int n;
      n = 0;
      prev = digit_sel;
      @(negedge clk);
      while (!(prev != 4'b0001 && digit_sel == 4'b0001) && n < 64) begin
         prev = digit_sel;
         @(negedge clk);
         n++;
      end
      ok = (n < 64);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (count_bcd !== 16'h0000 || digit_sel !== 4'b0001 || digit !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got cnt=%h sel=%b dig=%h wrap=%b expected 0000/0001/0/0",
                     count_bcd, digit_sel, digit, wrap);
         end
      end
      en = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (count_bcd !== 16'h0000) begin
         errors++;
         $display("FAIL reset_idle: got %h expected 0000", count_bcd);
      end
      en = 1'b1; up = 1'b1;
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (count_bcd !== 16'h0001) begin
         errors++;
         $display("FAIL first_step: got %h expected 0001", count_bcd);
      end
      exp_cnt = 1;
      do_clear();
   endtask

   task automatic test_wrap();
      en = 1'b1; up = 1'b0;
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (count_bcd !== 16'h9999 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_down: got cnt=%h wrap=%b expected 9999/1", count_bcd, wrap);
      end
      @(negedge clk);
      checks++;
      if (count_bcd !== 16'h9999 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_down_end: got cnt=%h wrap=%b expected 9999/0", count_bcd, wrap);
      end
      en = 1'b1; up = 1'b1;
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (count_bcd !== 16'h0000 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_up: got cnt=%h wrap=%b expected 0000/1", count_bcd, wrap);
      end
      @(negedge clk);
      checks++;
      if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_up_end: got cnt=%h wrap=%b expected 0000/0", count_bcd, wrap);
      end
      exp_cnt = 0;
   endtask

   task automatic test_carry();
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         exp_cnt = i;
         checks++;
         if (count_bcd !== to_bcd(i) || wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry_step: got cnt=%h wrap=%b expected %h/0", count_bcd, wrap, to_bcd(i));
         end
      end
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (count_bcd !== 16'h1000) begin
         errors++;
         $display("FAIL carry_hold: got %h expected 1000", count_bcd);
      end
      do_clear();
   endtask

   task automatic test_clr();
      bit ok;
      do_steps(42, 1'b1);
      sync_scan(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clr_sync: got timeout expected scan start");
      end
      clr = 1'b1; en = 1'b1; up = 1'b1;
      @(negedge clk);
      clr = 1'b0; en = 1'b0;
      exp_cnt = 0;
      checks++;
      if (count_bcd !== 16'h0000 || wrap !== 1'b0 || digit_sel !== 4'b0001 || digit !== 4'd0) begin
         errors++;
         $display("FAIL clr_en: got cnt=%h wrap=%b sel=%b dig=%h expected 0000/0/0001/0",
                  count_bcd, wrap, digit_sel, digit);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (digit_sel !== 4'b0001) begin
         errors++;
         $display("FAIL clr_scan_k3: got %b expected 0001", digit_sel);
      end
      @(negedge clk);
      checks++;
      if (digit_sel !== model_sel(1, 0) || digit !== 4'd0) begin
         errors++;
         $display("FAIL clr_scan_k4: got sel=%b dig=%h expected %b/0", digit_sel, digit, model_sel(1, 0));
      end
   endtask

   task automatic check_scan_cycle(input string name);
      bit ok;
      sync_scan(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_sync: got timeout expected scan start", name);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (digit_sel !== model_sel(k / 4, exp_cnt) || digit !== model_digit(k / 4, exp_cnt)) begin
            errors++;
            $display("FAIL %s k=%0d: got sel=%b dig=%h expected %b/%h", name, k, digit_sel, digit,
                     model_sel(k / 4, exp_cnt), model_digit(k / 4, exp_cnt));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_scan();
      do_clear();
      do_steps(1234, 1'b1);
      checks++;
      if (count_bcd !== 16'h1234) begin
         errors++;
         $display("FAIL scan_count: got %h expected 1234", count_bcd);
      end
      check_scan_cycle("scan_1234");
   endtask

   task automatic test_blanking();
      do_clear();
      do_steps(7, 1'b1);
      check_scan_cycle("blank_0007");
   endtask

   task automatic test_async_reset();
      do_steps(3, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (count_bcd !== 16'h0000 || digit_sel !== 4'b0001 || digit !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got cnt=%h sel=%b dig=%h wrap=%b expected 0000/0001/0/0",
                  count_bcd, digit_sel, digit, wrap);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (digit_sel !== model_sel(k / 4, 0)) begin
            errors++;
            $display("FAIL restart_scan k=%0d: got %b expected %b", k, digit_sel, model_sel(k / 4, 0));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      up      = 1'b1;
      clr     = 1'b0;
      test_reset();
      test_wrap();
      test_carry();
      test_clr();
      test_scan();
      test_blanking();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bcd_scan_counter
